// File: rtl/exp_pulse_gen.sv
// rtl/exp_pulse_gen.sv - step-rise, exponential-decay pulse source with pile-up and trigger holdoff
module exp_pulse_gen #(
  parameter int DATA_W      = 16,
  parameter int FRAC_W      = 8,
  parameter int DECAY_SHIFT = 4,
  parameter int HOLDOFF     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] baseline,
  input  logic                     trig_valid,
  input  logic [DATA_W-2:0]        trig_amp,
  output logic                     trig_ready,
  output logic signed [DATA_W-1:0] pulse_data,
  output logic                     busy,
  output logic [15:0]              evt_cnt
);

  localparam int ACC_W  = DATA_W - 1 + FRAC_W;
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic {IDLE, DECAY} state_t;

  state_t                     state_q, state_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [HOLD_W-1:0]          hold_q, hold_d;
  logic [15:0]                evt_q, evt_d;
  logic signed [DATA_W-1:0]   pdata_q, pdata_d;

  logic                       accept;
  logic [ACC_W-1:0]           decay;
  logic [ACC_W-1:0]           add;
  logic [ACC_W:0]             sum;
  logic signed [DATA_W:0]     out_sum;

  assign trig_ready = enable && (hold_q == '0) && !reset;
  assign accept     = trig_valid && trig_ready;
  assign busy       = (state_q == DECAY);
  assign pulse_data = pdata_q;
  assign evt_cnt    = evt_q;

  always_comb begin
    decay   = acc_q >> DECAY_SHIFT;
    add     = accept ? {trig_amp, {FRAC_W{1'b0}}} : '0;
    sum     = {1'b0, acc_q - decay} + {1'b0, add};
    acc_d   = acc_q;
    state_d = state_q;

    // decay==0 is exactly acc < 2^DECAY_SHIFT: cut the tail unless a new pulse lands
    if ((decay == '0) && !accept) begin
      acc_d = '0;
    end else if (sum[ACC_W]) begin
      acc_d = '1;
    end else begin
      acc_d = sum[ACC_W-1:0];
    end

    case (state_q)
      IDLE:    if (accept && (acc_d != '0)) state_d = DECAY;
      DECAY:   if (acc_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      hold_d = HOLD_W'(HOLDOFF);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end else begin
      hold_d = '0;
    end

    evt_d = evt_q + 16'(accept);

    out_sum = $signed({2'b00, acc_q[ACC_W-1:FRAC_W]}) + $signed({baseline[DATA_W-1], baseline});
    if (out_sum[DATA_W] != out_sum[DATA_W-1]) begin
      pdata_d = out_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      pdata_d = out_sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      hold_q  <= '0;
      evt_q   <= '0;
      pdata_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      hold_q  <= hold_d;
      evt_q   <= evt_d;
      pdata_q <= pdata_d;
    end
  end

endmodule

// File: doc/exp_pulse_gen.md
# exp_pulse_gen

Synthetic detector-pulse source for the shaping-filter chain. It generates a stream of signed samples shaped as step-rise, exponential-decay pulses, which is the waveform the trapezoidal shaper deconvolves. Pulses are triggered through a valid/ready handshake and may pile up. The output drives the shaper input directly for bench and in-system self-test.

## Interface
- DATA_W, 16, sample width; matches the shaper data width
- FRAC_W, 8, fractional bits of the internal accumulator
- DECAY_SHIFT, 4, decay per clock is acc >>> DECAY_SHIFT; tau ≈ 2^DECAY_SHIFT clocks
- HOLDOFF, 8, clocks after an accepted trigger during which trig_ready is low; 0 means a trigger can be accepted every cycle
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  trigger gate; decay continues while low
- baseline  in  DATA_W signed  offset added to every output sample
- trig_valid  in  1  trigger request
- trig_amp  in  DATA_W-1 unsigned  pulse amplitude in output LSBs
- trig_ready  out  1  trigger accepted when trig_valid && trig_ready
- pulse_data  out  DATA_W signed  registered output sample
- busy  out  1  state is DECAY
- evt_cnt  out  16  accepted-trigger count, wraps at 65535→0

## Operation
- Accumulator acc is unsigned, DATA_W-1+FRAC_W bits. ACC_MAX is all ones.
- FSM IDLE (acc==0) / DECAY (acc!=0). busy = (state==DECAY).
- accept = trig_valid && trig_ready.
- trig_ready = enable && (hold_cnt==0) && !reset. It is combinational from registered state.
- Per clock, decay term d = acc >> DECAY_SHIFT.
  - If acc < 2^DECAY_SHIFT and there is no accept: acc ← 0. This is the tail cut, and the FSM goes to IDLE.
  - Otherwise acc ← sat(acc − d + (accept ? trig_amp<<FRAC_W : 0)), saturating at ACC_MAX.
- In IDLE, accept moves the FSM to DECAY.
- Pile-up: an accept in DECAY adds the new amplitude to the already-decayed value in the same cycle.
- hold_cnt behaviour:
  - accept loads hold_cnt with HOLDOFF.
  - Otherwise hold_cnt decrements toward 0.
  - With HOLDOFF=0 it stays 0.
- evt_cnt increments by 1 on each accept.
- Output: pulse_data ← sat_signed((acc >> FRAC_W) + baseline). Saturation is to [−2^(DATA_W-1), 2^(DATA_W-1)−1].
- Reset (any cycle, including mid-pulse) gives, at the next edge:
  - acc=0, state IDLE, hold_cnt=0, evt_cnt=0, pulse_data=0.
  - trig_ready is 0 while reset is high. busy=0.
  - Baseline is not applied during reset.

## Timing
- Trigger accepted at edge N: acc holds trig_amp<<FRAC_W after edge N. pulse_data = trig_amp + baseline after edge N+1, which is 2-clock latency.
- Decay: sample j after the peak is acc_j >> FRAC_W, where acc_{j+1} = acc_j − (acc_j >> DECAY_SHIFT).
- Holdoff: after accept at edge N, trig_ready is low for cycles N+1 … N+HOLDOFF and high again in cycle N+HOLDOFF+1 (if enable is high).
- trig_ready is 1 in the first cycle after reset deasserts, given enable=1.
- Tail cut: acc reaches 0 exactly one edge after acc < 2^DECAY_SHIFT. busy falls at that same edge. pulse_data shows baseline one edge later.
- Simultaneous accept and tail-cut condition: the accept wins and the add path is used.
- Holding trig_valid high with HOLDOFF=0 accepts every cycle. acc saturates and holds pulse_data at 32767+baseline (before signed saturation).

## Test plan
- Single pulse: DECAY_SHIFT=4, FRAC_W=8, baseline=0, accept trig_amp=1000 at edge N.
  - Expect pulse_data 1000, 937, 878 at edges N+1, N+2, N+3.
  - Expect busy=1 through the tail, then IDLE with pulse_data=0.
- Pile-up: accept 1000, then accept 500 three cycles later.
  - acc = 225000 − 14062 + 128000 = 338938, so pulse_data=1323 one edge after that.
  - evt_cnt=2.
- Holdoff: HOLDOFF=8 with trig_valid held high.
  - Accepts occur only every 9th cycle.
  - evt_cnt=3 after 19 cycles starting from the first accept.
- Saturation: HOLDOFF=0, trig_amp=32767 every cycle, baseline=100 → pulse_data holds 32767.
  - With baseline=−40000 clamped input range (baseline=−32768) and acc=0 → pulse_data=−32768.
- Reset mid-pulse: assert reset while pulse_data≈900.
  - Next edge gives pulse_data=0, busy=0, evt_cnt=0, trig_ready=0 during reset.
  - After release, a new accept of 200 yields 200 two edges later.
- Enable gating: enable=0 with trig_valid=1 → no accepts, evt_cnt unchanged, existing pulse continues to decay to 0.
